// File: rtl/urv_imem_bridge_if.sv
// Pipelined Wishbone-style instruction read bus between the uRV fetch bridge and memory.
interface urv_imem_bridge_if;
    logic [31:0] ib_adr_o;
    logic        ib_cyc_o;
    logic        ib_stb_o;
    logic        ib_stall_i;
    logic        ib_ack_i;
    logic        ib_err_i;
    logic [31:0] ib_dat_i;

    modport master (
        output ib_adr_o, ib_cyc_o, ib_stb_o,
        input  ib_stall_i, ib_ack_i, ib_err_i, ib_dat_i
    );

    modport slave (
        input  ib_adr_o, ib_cyc_o, ib_stb_o,
        output ib_stall_i, ib_ack_i, ib_err_i, ib_dat_i
    );
endinterface

// File: rtl/urv_imem_bridge.sv
// uRV fetch-port to instruction-bus bridge: one-entry instruction buffer, single-outstanding
// bus reads on a miss, fence.i flush, bus watchdog and error reporting.
module urv_imem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [31:0]               im_addr_i,
    output logic [31:0]               im_data_o,
    output logic                      im_valid_o,
    output logic                      im_err_o,
    input  logic                      flush_i,
    output logic [31:0]               miss_cnt_o,
    urv_imem_bridge_if.master         ib
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [31:0] addr_p0;
    logic [31:0] req_addr;
    logic [31:0] buf_addr;
    logic [31:0] buf_data;
    logic        buf_vld;
    logic        discard;
    logic [15:0] wdog;

    logic hit;
    logic issue;
    logic timeout;
    logic abort;
    logic fill;
    logic done;

    always_comb begin
        addr_p0 = {im_addr_i[31:2], 2'b00};
        hit     = buf_vld && (addr_p0 == buf_addr) && !flush_i;
        issue   = (state == ST_IDLE) && !hit && !flush_i;
        timeout = (state == ST_WAIT) && (wdog == WDOG_LAST);
        // err beats ack; a timeout only fires when the slave stayed silent that cycle
        abort   = (state == ST_WAIT) && (ib.ib_err_i || (timeout && !ib.ib_ack_i));
        fill    = (state == ST_WAIT) && ib.ib_ack_i && !ib.ib_err_i && !discard && !flush_i;
        done    = (state == ST_WAIT) && (ib.ib_ack_i || ib.ib_err_i || timeout);
    end

    always_ff @(posedge clk_i) begin
        if (issue) begin
            req_addr <= addr_p0;
        end
        if (fill) begin
            buf_addr <= req_addr;
            buf_data <= ib.ib_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            buf_vld     <= 1'b0;
            discard     <= 1'b0;
            wdog        <= 16'd0;
            im_valid_o  <= 1'b0;
            im_err_o    <= 1'b0;
            im_data_o   <= 32'd0;
            ib.ib_adr_o <= 32'd0;
            ib.ib_cyc_o <= 1'b0;
            ib.ib_stb_o <= 1'b0;
            miss_cnt_o  <= 32'd0;
        end else begin
            im_valid_o <= hit;
            im_err_o   <= 1'b0;
            if (hit) begin
                im_data_o <= buf_data;
            end
            if (flush_i) begin
                buf_vld <= 1'b0;
            end
            if (flush_i && (state != ST_IDLE)) begin
                discard <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        ib.ib_adr_o <= addr_p0;
                        ib.ib_cyc_o <= 1'b1;
                        ib.ib_stb_o <= 1'b1;
                        miss_cnt_o  <= miss_cnt_o + 32'd1;
                        state       <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (!ib.ib_stall_i) begin
                        ib.ib_stb_o <= 1'b0;
                        wdog        <= 16'd0;
                        state       <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    wdog <= wdog + 16'd1;
                    if (fill) begin
                        buf_vld <= 1'b1;
                        // fetch still waiting on this very word: forward it straight away
                        if (addr_p0 == req_addr) begin
                            im_valid_o <= 1'b1;
                            im_data_o  <= ib.ib_dat_i;
                        end
                    end
                    if (abort) begin
                        buf_vld  <= 1'b0;
                        im_err_o <= !discard && !flush_i && !hit;
                    end
                    if (done) begin
                        ib.ib_cyc_o <= 1'b0;
                        discard     <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_urv_imem_bridge.sv
// Directed, table-driven bench for urv_imem_bridge with a 4-cycle bus watchdog.
module tb_urv_imem_bridge;

    logic        clk;
    logic        rst_n;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic        im_valid;
    logic        im_err;
    logic        flush;
    logic [31:0] miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    urv_imem_bridge_if bus ();

    urv_imem_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .im_addr_i  (im_addr),
        .im_data_o  (im_data),
        .im_valid_o (im_valid),
        .im_err_o   (im_err),
        .flush_i    (flush),
        .miss_cnt_o (miss_cnt),
        .ib         (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        flush;
        logic        stall;
        logic        ack;
        logic        err;
        logic [31:0] dat;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_err;
        logic        e_cyc;
        logic        e_stb;
        logic [31:0] e_adr;
        logic [31:0] e_miss;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic [31:0] a, logic fl, logic st, logic ak,
                                logic er, logic [31:0] d, logic ev, logic [31:0] ed,
                                logic ee, logic ec, logic es, logic [31:0] ead,
                                logic [31:0] em);
        vec_t v;
        v.name = nm; v.addr = a; v.flush = fl; v.stall = st; v.ack = ak; v.err = er;
        v.dat = d; v.e_valid = ev; v.e_data = ed; v.e_err = ee; v.e_cyc = ec;
        v.e_stb = es; v.e_adr = ead; v.e_miss = em;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(logic [31:0] a, logic fl, logic st, logic ak, logic er, logic [31:0] d);
        im_addr        = a;
        flush          = fl;
        bus.ib_stall_i = st;
        bus.ib_ack_i   = ak;
        bus.ib_err_i   = er;
        bus.ib_dat_i   = d;
    endtask

    task automatic check_idle_reset(string tag);
        chk({tag, "_valid"}, {31'd0, im_valid}, 32'd0);
        chk({tag, "_err"},   {31'd0, im_err},   32'd0);
        chk({tag, "_data"},  im_data,           32'd0);
        chk({tag, "_cyc"},   {31'd0, bus.ib_cyc_o}, 32'd0);
        chk({tag, "_stb"},   {31'd0, bus.ib_stb_o}, 32'd0);
        chk({tag, "_adr"},   bus.ib_adr_o,      32'd0);
        chk({tag, "_miss"},  miss_cnt,          32'd0);
    endtask

    initial begin
        // cold miss, then hits on the same word
        vecs.push_back(mk("cold0", 32'h0,   0,0,0,0, 32'h0,        0,32'h0,        0,1,1,32'h0,  1));
        vecs.push_back(mk("cold1", 32'h0,   0,0,0,0, 32'h0,        0,32'h0,        0,1,0,32'h0,  1));
        vecs.push_back(mk("cold2", 32'h0,   0,0,1,0, 32'h13,       1,32'h13,       0,0,0,32'h0,  1));
        vecs.push_back(mk("rep0",  32'h0,   0,0,0,0, 32'h0,        1,32'h13,       0,0,0,32'h0,  1));
        vecs.push_back(mk("rep1",  32'h0,   0,0,0,0, 32'h0,        1,32'h13,       0,0,0,32'h0,  1));
        vecs.push_back(mk("rep2",  32'h0,   0,0,0,0, 32'h0,        1,32'h13,       0,0,0,32'h0,  1));
        vecs.push_back(mk("rep3",  32'h0,   0,0,0,0, 32'h0,        1,32'h13,       0,0,0,32'h0,  1));
        // stall for three cycles while fetch branches from 0x100 to 0x200
        vecs.push_back(mk("stl0",  32'h100, 0,0,0,0, 32'h0,        0,32'h0,        0,1,1,32'h100,2));
        vecs.push_back(mk("stl1",  32'h100, 0,1,0,0, 32'h0,        0,32'h0,        0,1,1,32'h100,2));
        vecs.push_back(mk("stl2",  32'h200, 0,1,0,0, 32'h0,        0,32'h0,        0,1,1,32'h100,2));
        vecs.push_back(mk("stl3",  32'h200, 0,1,0,0, 32'h0,        0,32'h0,        0,1,1,32'h100,2));
        vecs.push_back(mk("stl4",  32'h200, 0,0,0,0, 32'h0,        0,32'h0,        0,1,0,32'h100,2));
        vecs.push_back(mk("stl5",  32'h200, 0,0,1,0, 32'hAAAA0100, 0,32'h0,        0,0,0,32'h100,2));
        vecs.push_back(mk("br0",   32'h200, 0,0,0,0, 32'h0,        0,32'h0,        0,1,1,32'h200,3));
        vecs.push_back(mk("br1",   32'h200, 0,0,0,0, 32'h0,        0,32'h0,        0,1,0,32'h200,3));
        vecs.push_back(mk("br2",   32'h200, 0,0,1,0, 32'hBBBB0200, 1,32'hBBBB0200, 0,0,0,32'h200,3));
        vecs.push_back(mk("br3",   32'h200, 0,0,0,0, 32'h0,        1,32'hBBBB0200, 0,0,0,32'h200,3));
        vecs.push_back(mk("byte",  32'h202, 0,0,0,0, 32'h0,        1,32'hBBBB0200, 0,0,0,32'h200,3));
        // flush while waiting for 0x40 discards the response
        vecs.push_back(mk("fl0",   32'h40,  0,0,0,0, 32'h0,        0,32'h0,        0,1,1,32'h40, 4));
        vecs.push_back(mk("fl1",   32'h40,  0,0,0,0, 32'h0,        0,32'h0,        0,1,0,32'h40, 4));
        vecs.push_back(mk("fl2",   32'h40,  1,0,0,0, 32'h0,        0,32'h0,        0,1,0,32'h40, 4));
        vecs.push_back(mk("fl3",   32'h40,  0,0,1,0, 32'hDEADBEEF, 0,32'h0,        0,0,0,32'h40, 4));
        vecs.push_back(mk("fl4",   32'h40,  0,0,0,0, 32'h0,        0,32'h0,        0,1,1,32'h40, 5));
        vecs.push_back(mk("fl5",   32'h40,  0,0,0,0, 32'h0,        0,32'h0,        0,1,0,32'h40, 5));
        vecs.push_back(mk("fl6",   32'h40,  0,0,1,0, 32'h00400040, 1,32'h00400040, 0,0,0,32'h40, 5));
        // flush while idle on a hit: no valid, no request, buffer dropped
        vecs.push_back(mk("fli0",  32'h40,  1,0,0,0, 32'h0,        0,32'h0,        0,0,0,32'h40, 5));
        vecs.push_back(mk("fli1",  32'h40,  0,0,0,0, 32'h0,        0,32'h0,        0,1,1,32'h40, 6));
        vecs.push_back(mk("fli2",  32'h40,  0,0,0,0, 32'h0,        0,32'h0,        0,1,0,32'h40, 6));
        vecs.push_back(mk("fli3",  32'h40,  0,0,1,0, 32'h00400041, 1,32'h00400041, 0,0,0,32'h40, 6));
        // bus error (with a simultaneous ack) then a clean retry
        vecs.push_back(mk("er0",   32'h80,  0,0,0,0, 32'h0,        0,32'h0,        0,1,1,32'h80, 7));
        vecs.push_back(mk("er1",   32'h80,  0,0,0,0, 32'h0,        0,32'h0,        0,1,0,32'h80, 7));
        vecs.push_back(mk("er2",   32'h80,  0,0,1,1, 32'h11111111, 0,32'h0,        1,0,0,32'h80, 7));
        vecs.push_back(mk("er3",   32'h80,  0,0,0,0, 32'h0,        0,32'h0,        0,1,1,32'h80, 8));
        vecs.push_back(mk("er4",   32'h80,  0,0,0,0, 32'h0,        0,32'h0,        0,1,0,32'h80, 8));
        vecs.push_back(mk("er5",   32'h80,  0,0,1,0, 32'h12345678, 1,32'h12345678, 0,0,0,32'h80, 8));
        // watchdog abort after four silent WAIT cycles, late ack ignored
        vecs.push_back(mk("to0",   32'h300, 0,0,0,0, 32'h0,        0,32'h0,        0,1,1,32'h300,9));
        vecs.push_back(mk("to1",   32'h300, 0,0,0,0, 32'h0,        0,32'h0,        0,1,0,32'h300,9));
        vecs.push_back(mk("to2",   32'h300, 0,0,0,0, 32'h0,        0,32'h0,        0,1,0,32'h300,9));
        vecs.push_back(mk("to3",   32'h300, 0,0,0,0, 32'h0,        0,32'h0,        0,1,0,32'h300,9));
        vecs.push_back(mk("to4",   32'h300, 0,0,0,0, 32'h0,        0,32'h0,        0,1,0,32'h300,9));
        vecs.push_back(mk("to5",   32'h300, 0,0,0,0, 32'h0,        0,32'h0,        1,0,0,32'h300,9));
        vecs.push_back(mk("to6",   32'h300, 1,0,0,0, 32'h0,        0,32'h0,        0,0,0,32'h300,9));
        vecs.push_back(mk("to7",   32'h300, 1,0,1,0, 32'hBAD0BAD0, 0,32'h0,        0,0,0,32'h300,9));
        vecs.push_back(mk("to8",   32'h300, 0,0,0,0, 32'h0,        0,32'h0,        0,1,1,32'h300,10));
        vecs.push_back(mk("to9",   32'h300, 0,0,0,0, 32'h0,        0,32'h0,        0,1,0,32'h300,10));
        vecs.push_back(mk("to10",  32'h300, 0,0,1,0, 32'h00300300, 1,32'h00300300, 0,0,0,32'h300,10));

        rst_n = 1'b0;
        drive(32'h0, 0, 0, 0, 0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_idle_reset("rst");
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].addr, vecs[i].flush, vecs[i].stall, vecs[i].ack, vecs[i].err, vecs[i].dat);
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_valid"}, {31'd0, im_valid},     {31'd0, vecs[i].e_valid});
            chk({vecs[i].name, "_err"},   {31'd0, im_err},       {31'd0, vecs[i].e_err});
            chk({vecs[i].name, "_cyc"},   {31'd0, bus.ib_cyc_o}, {31'd0, vecs[i].e_cyc});
            chk({vecs[i].name, "_stb"},   {31'd0, bus.ib_stb_o}, {31'd0, vecs[i].e_stb});
            chk({vecs[i].name, "_miss"},  miss_cnt,              vecs[i].e_miss);
            if (vecs[i].e_cyc)
                chk({vecs[i].name, "_adr"}, bus.ib_adr_o, vecs[i].e_adr);
            if (vecs[i].e_valid)
                chk({vecs[i].name, "_data"}, im_data, vecs[i].e_data);
        end

        // reset asserted between clock edges while a request is outstanding
        drive(32'h500, 0, 1, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        chk("mid_cyc_before", {31'd0, bus.ib_cyc_o}, 32'd1);
        chk("mid_adr_before", bus.ib_adr_o, 32'h500);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_reset("mid");
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h600, 0, 0, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_stb",  {31'd0, bus.ib_stb_o}, 32'd1);
        chk("post_rst_adr",  bus.ib_adr_o, 32'h600);
        chk("post_rst_miss", miss_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
